// File: rtl/branch_resolve_bht.sv
// Branch resolution with a 2-bit saturating-counter BHT; an INIT sweep clears the table after reset.
// Optional macro BRANCH_BHT_BYPASS_EN forwards a same-cycle update to a colliding lookup.
module branch_resolve_bht #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_fetchValid,
  input  logic [PC_WIDTH-1:0] i_fetchPC,
  output logic                o_predictTaken,
  output logic                o_predictValid,
  output logic                o_ready,
  input  logic                i_valid,
  input  logic [2:0]          i_funct3,
  input  logic                i_isEqual,
  input  logic                i_isLessSigned,
  input  logic                i_isLessUnsigned,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [PC_WIDTH-1:0] i_target,
  input  logic                i_predicted,
  output logic                o_taken,
  output logic                o_mispredict,
  output logic [PC_WIDTH-1:0] o_redirectPC,
  output logic                o_illegal
);

  localparam int ENTRIES = 2**INDEX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   sweep_q;
  logic [1:0]              counter [ENTRIES];
  logic                    run;

  logic [INDEX_BITS-1:0]   fetch_idx_p0, upd_idx_p0;
  logic                    illegal_p0, taken_p0, vld_p0, lookup_vld_p0;
  logic                    upd_en_p0, mispredict_p0, pred_p0;
  logic [1:0]              read_ctr_p0, upd_ctr_p0;
  logic [PC_WIDTH-1:0]     redirect_p0;
  logic                    unused_fetch_pc;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    if (up)
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

  // funct3[0] inverts the base comparison selected by funct3[2:1]
  function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                       input logic lts, input logic ltu);
    logic c;
    case (f3[2:1])
      2'b00:   c = eq;
      2'b10:   c = lts;
      2'b11:   c = ltu;
      default: c = 1'b0;
    endcase
    return c ^ f3[0];
  endfunction

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT)
        sweep_q <= sweep_q + INDEX_BITS'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && (&sweep_q))
      state_d = RUN;
  end

  always_comb begin
    run     = (state_q == RUN);
    o_ready = run;
  end

  // Stage p0: decode, table read and counter update computed from current inputs
  always_comb begin
    fetch_idx_p0  = i_fetchPC[INDEX_BITS+1:2];
    upd_idx_p0    = i_pc[INDEX_BITS+1:2];
    illegal_p0    = (i_funct3[2:1] == 2'b01);
    taken_p0      = !illegal_p0 && branch_cond(i_funct3, i_isEqual, i_isLessSigned, i_isLessUnsigned);
    vld_p0        = run && i_valid;
    lookup_vld_p0 = run && i_fetchValid;
    upd_en_p0     = vld_p0 && !illegal_p0;
    upd_ctr_p0    = sat_update(counter[upd_idx_p0], taken_p0);
    read_ctr_p0   = counter[fetch_idx_p0];
`ifdef BRANCH_BHT_BYPASS_EN
    pred_p0       = (upd_en_p0 && upd_idx_p0 == fetch_idx_p0) ? upd_ctr_p0[1] : read_ctr_p0[1];
`else
    pred_p0       = read_ctr_p0[1];
`endif
    mispredict_p0 = upd_en_p0 && (taken_p0 != i_predicted);
    redirect_p0   = taken_p0 ? i_target : i_pc + PC_WIDTH'(4);
  end

  assign unused_fetch_pc = ^{i_fetchPC[PC_WIDTH-1:INDEX_BITS+2], i_fetchPC[1:0]};

  // Single write port: INIT sweep or resolution update, never both
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      if (state_q == INIT)
        counter[sweep_q] <= 2'b01;
      else if (upd_en_p0)
        counter[upd_idx_p0] <= upd_ctr_p0;
    end
  end

  // Stage p1: registered prediction and resolution outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_predictValid <= 1'b0;
      o_predictTaken <= 1'b0;
      o_taken        <= 1'b0;
      o_mispredict   <= 1'b0;
      o_illegal      <= 1'b0;
      o_redirectPC   <= '0;
    end else begin
      o_predictValid <= lookup_vld_p0;
      if (lookup_vld_p0)
        o_predictTaken <= pred_p0;
      o_taken      <= vld_p0 && taken_p0;
      o_mispredict <= mispredict_p0;
      o_illegal    <= vld_p0 && illegal_p0;
      if (mispredict_p0)
        o_redirectPC <= redirect_p0;
    end
  end

endmodule
